// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating bubble counter.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic inFire;
  logic outFire;

  assign inFire  = in_valid && in_ready;
  assign outFire = out_valid && out_ready;

  // Starved cycles: downstream ready but nothing to offer; flush does not touch it.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      bubble_cnt <= '0;
    end else if (!out_valid && out_ready && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [DATA_W-1:0] mainData;
  logic [DATA_W-1:0] mainDataNext;
  logic [CTRL_W-1:0] mainCtrl;
  logic [CTRL_W-1:0] mainCtrlNext;
  logic [DATA_W-1:0] skidData;
  logic [DATA_W-1:0] skidDataNext;
  logic [CTRL_W-1:0] skidCtrl;
  logic [CTRL_W-1:0] skidCtrlNext;
  logic              inReadyQ;

  always_comb begin
    stateNext    = state;
    mainDataNext = mainData;
    mainCtrlNext = mainCtrl;
    skidDataNext = skidData;
    skidCtrlNext = skidCtrl;
    if (flush) begin
      stateNext    = EMPTY;
      mainDataNext = '0;
      mainCtrlNext = '0;
      skidDataNext = '0;
      skidCtrlNext = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            stateNext    = ONE;
            mainDataNext = in_data;
            mainCtrlNext = in_ctrl;
          end
        end
        ONE: begin
          case ({inFire, outFire})
            2'b11: begin
              mainDataNext = in_data;
              mainCtrlNext = in_ctrl;
            end
            2'b10: begin
              stateNext    = TWO;
              skidDataNext = in_data;
              skidCtrlNext = in_ctrl;
            end
            2'b01: begin
              stateNext    = EMPTY;
              mainDataNext = '0;
              mainCtrlNext = '0;
            end
            default: ;
          endcase
        end
        TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (outFire) begin
            stateNext    = ONE;
            mainDataNext = skidData;
            mainCtrlNext = skidCtrl;
            skidDataNext = '0;
            skidCtrlNext = '0;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= EMPTY;
      mainData <= '0;
      mainCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
      inReadyQ <= 1'b1;
    end else begin
      state    <= stateNext;
      mainData <= mainDataNext;
      mainCtrl <= mainCtrlNext;
      skidData <= skidDataNext;
      skidCtrl <= skidCtrlNext;
      inReadyQ <= (stateNext != TWO);
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = (state != EMPTY);
  assign out_data  = mainData;
  assign out_ctrl  = mainCtrl;

`else

  logic              validQ;
  logic [DATA_W-1:0] dataQ;
  logic [CTRL_W-1:0] ctrlQ;

  always_ff @(posedge CLK) begin
    if (CLR || flush) begin
      validQ <= 1'b0;
      dataQ  <= '0;
      ctrlQ  <= '0;
    end else if (inFire) begin
      validQ <= 1'b1;
      dataQ  <= in_data;
      ctrlQ  <= in_ctrl;
    end else if (outFire) begin
      validQ <= 1'b0;
      dataQ  <= '0;
      ctrlQ  <= '0;
    end
  end

  assign in_ready  = !validQ || out_ready;
  assign out_valid = validQ;
  assign out_data  = dataQ;
  assign out_ctrl  = ctrlQ;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed literal checks.
// Follows the PIPE_SKID_EN setting of the design build.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 12;
  localparam int NW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] bubble_cnt;

  logic          in_ready4;
  logic          out_valid4;
  logic [7:0]    out_data4;
  logic [3:0]    out_ctrl4;
  logic [3:0]    bubble_cnt4;

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  int unsigned mCnt = 0;
  int unsigned mCnt4 = 0;
  bit          modelOn = 1'b0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
  );

  // Permanently idle narrow instance: exercises counter saturation.
  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dut4 (
    .CLK(CLK), .CLR(CLR), .in_valid(1'b0), .in_ready(in_ready4),
    .in_data(8'h00), .in_ctrl(4'h0), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_ctrl(out_ctrl4), .bubble_cnt(bubble_cnt4)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: a FIFO of capacity 1 (or 2 with skid), updated per edge.
  always @(posedge CLK) begin
    bit ov;
    bit ir;
    if (CLR) begin
      q.delete();
      mCnt    = 0;
      mCnt4   = 0;
      modelOn = 1'b1;
    end else begin
      ov = (q.size() > 0);
`ifdef PIPE_SKID_EN
      ir = (q.size() < 2);
`else
      ir = !ov || out_ready;
`endif
      if (!ov && out_ready && mCnt < 65535) mCnt++;
      if (out_ready && mCnt4 < 15) mCnt4++;
      if (flush) begin
        q.delete();
      end else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back({in_ctrl, in_data});
      end
    end
  end

  always @(negedge CLK) begin
    logic ev;
    logic eir;
    ent_t e;
    if (modelOn) begin
      ev = (q.size() > 0);
      e  = ev ? q[0] : '0;
`ifdef PIPE_SKID_EN
      eir = (q.size() < 2);
`else
      eir = !ev || out_ready;
`endif
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_data", out_data, e.d);
      chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
      chk("in_ready", 64'(in_ready), 64'(eir));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(mCnt));
      chk("narrow_bubble_cnt", 64'(bubble_cnt4), 64'(mCnt4));
      chk("narrow_out_valid", 64'(out_valid4), 64'd0);
    end
  end

  initial begin
    CLR = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 12'hFFF;
    step();
    CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("ready_after_clr", 64'(in_ready), 64'd1);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_cnt", 64'(bubble_cnt), 64'd0);
    repeat (5) step();
    chk("idle5_cnt", 64'(bubble_cnt), 64'd5);
    chk("idle5_valid", 64'(out_valid), 64'd0);
    chk("idle5_ctrl", 64'(out_ctrl), 64'd0);
    repeat (15) step();
    chk("idle20_cnt", 64'(bubble_cnt), 64'd20);
    chk("sat_cnt4", 64'(bubble_cnt4), 64'd15);

    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 12'(i);
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", out_data, 64'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA; in_ctrl = 12'h1;
    step();
    in_data = 64'hB; in_ctrl = 12'h2;
`ifdef PIPE_SKID_EN
    step();
    chk("skid_full_ready", 64'(in_ready), 64'd0);
    chk("skid_head", out_data, 64'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("skid_second", out_data, 64'hB);
    chk("skid_ready_back", 64'(in_ready), 64'd1);
`else
    #1;
    chk("full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("passthru_ready", 64'(in_ready), 64'd1);
    step();
    chk("replace_data", out_data, 64'hB);
    chk("replace_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
`endif
    step();
    chk("ab_drained", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hC; in_ctrl = 12'h3;
    step();
    chk("hold_c", out_data, 64'hC);
    in_data = 64'hD; in_ctrl = 12'h4; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", out_data, 64'd0);
    out_ready = 1'b1;
    repeat (3) step();

    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; in_ctrl = 12'h5;
    step();
    in_data = 64'h22; in_ctrl = 12'h6;
    step();
    CLR = 1'b1; flush = 1'b1; in_data = 64'h33;
    step();
    CLR = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_data", out_data, 64'd0);
    chk("clr_ctrl", 64'(out_ctrl), 64'd0);
    chk("clr_cnt", 64'(bubble_cnt), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);

    for (int blk = 0; blk < 15; blk++) begin
      int unsigned rdyPct;
      rdyPct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        CLR       = ($urandom_range(0, 299) == 0);
        flush     = ($urandom_range(0, 19) == 0);
        in_valid  = ($urandom_range(0, 99) < 65);
        out_ready = ($urandom_range(0, 99) < rdyPct);
        in_data   = {$urandom, $urandom};
        in_ctrl   = 12'($urandom);
        step();
      end
    end
    CLR = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: payload width (operands, immediates, PC+4, register indices packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 12: control-bit width (RegWrite, MemWrite, ALU control, etc.); all-zero encodes a bubble.
REQ-003 Parameter CNT_W, default 16: bubble counter width.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 CLR  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream holds valid payload.
REQ-007 in_ready  out  1  stage can accept this cycle.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 flush  in  1  squash all held entries (branch/jump/hazard kill).
REQ-011 out_valid  out  1  stage presents valid payload.
REQ-012 out_ready  in  1  downstream accepts this cycle.
REQ-013 out_data  out  DATA_W  held payload.
REQ-014 out_ctrl  out  CTRL_W  held control bits.
REQ-015 bubble_cnt  out  CNT_W  saturating count of starved cycles.

Function
REQ-016 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-017 Entries leave in arrival order; none duplicated or dropped, except by flush or CLR.
REQ-018 Latency: data accepted at edge N appears on out_* with out_valid=1 after edge N when the stage was empty.
REQ-019 out_data and out_ctrl are all-zero whenever out_valid=0.
REQ-020 out_data, out_ctrl, out_valid do not change while out_valid=1 and out_ready=0.
REQ-021 flush=1 at an edge invalidates all held entries, and any input transfer at that edge is discarded; out_valid=0 after the edge.
REQ-022 flush has priority over simultaneous input and output transfers; an output transfer at the flush edge still counts as consumed.
REQ-023 Simultaneous input and output transfer on a single full entry replaces it with the new payload; out_valid stays 1.
REQ-024 bubble_cnt increments by 1 at each edge where out_valid=0 and out_ready=1; holds at all-ones (saturates, no wrap).
REQ-025 bubble_cnt is unaffected by flush.

Reset
REQ-026 CLR=1 at an edge: out_valid=0, out_data=0, out_ctrl=0, skid entry empty, bubble_cnt=0; any input during that cycle discarded.
REQ-027 CLR has priority over flush and all transfers.
REQ-028 in_ready=1 in the first cycle after CLR deasserts.

Configuration
REQ-029 Macro PIPE_SKID_EN selects the buffering mode.
REQ-030 Without PIPE_SKID_EN: single entry; in_ready = !out_valid || out_ready, combinational from out_ready.
REQ-031 With PIPE_SKID_EN: two entries (main, skid); in_ready is a register output equal to "skid empty", with no combinational path from out_ready.
REQ-032 Skid mode states: EMPTY (none held), ONE (main held), TWO (main+skid held).
REQ-033 Skid transitions: EMPTY->ONE on input; ONE->TWO on input without output; ONE->EMPTY on output without input; TWO->ONE on output, skid moves to main; ONE stays ONE on input+output.
REQ-034 In TWO, in_ready=0; flush from any state -> EMPTY.
REQ-035 Both modes sustain one transfer per cycle when out_ready is held 1.

Verification
REQ-036 CLR 1 cycle, then out_ready=1 with in_valid=0 for 5 cycles -> out_valid=0, out_ctrl=0, bubble_cnt=5.
REQ-037 Stream 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8 in order, one per cycle, first one cycle after acceptance.
REQ-038 Skid mode: send 0xA, 0xB with out_ready=0 -> in_ready=0 after the second; raise out_ready -> 0xA then 0xB, in_ready returns to 1.
REQ-039 Hold 0xC with out_ready=0, assert flush together with in_valid carrying 0xD -> out_valid=0 next cycle; 0xD never appears.
REQ-040 CNT_W=4, out_ready=1, idle 20 cycles -> bubble_cnt stops at 15.
REQ-041 Assert CLR while in TWO with flush=1 -> all outputs zero, bubble_cnt=0, in_ready=1 next cycle.
